vcm_peak_track: RTL and testbench

VCM_PEAK_TRACK -- requirements
Module: vcm_peak_track

---
 rtl/vcm_peak_track.sv | 165 ++++++++++++++++
 tb/tb_vcm_peak_track.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vcm_peak_track.sv
// rtl/vcm_peak_track.sv - VCM autofocus peak tracker (coarse/fine sweep, best-step capture)
//
// Tracks the maximum frame sharpness during a coarse lens sweep and then during a
// fine sweep, and captures the lens step at which each maximum occurred.
//
// Parameters
//   SETTLE       sharpness samples discarded after every STEP change (0..15)
//   SW           sharpness word width
//
// Ports
//   CLK          clock, all state changes on its rising edge
//   RESET_n      asynchronous active-low reset
//   STEP         current lens step from the step generator (11 bits)
//   V_C          sweep select: 0 = coarse, 1 = fine
//   VCM_END      fine sweep finished (level)
//   SHARP_VALID  one-cycle strobe per frame qualifying SHARP
//   SHARP        frame sharpness sum
//   STEP_UP      best coarse step, fed back as the fine-sweep centre
//   BEST_STEP    best fine step, the final focus position
//   PEAK_VAL     running maximum sharpness of the current phase
//   BUSY         high while sweeping (coarse or fine)
//   DONE         high once the fine sweep has finished

module vcm_peak_track #(
    parameter int SETTLE = 2,
    parameter int SW     = 24
) (
    input  logic          CLK,
    input  logic          RESET_n,
    input  logic [10:0]   STEP,
    input  logic          V_C,
    input  logic          VCM_END,
    input  logic          SHARP_VALID,
    input  logic [SW-1:0] SHARP,
    output logic [9:0]    STEP_UP,
    output logic [9:0]    BEST_STEP,
    output logic [SW-1:0] PEAK_VAL,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COARSE = 2'd1,
        S_FINE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [10:0] step_q;
    logic        vc_q;
    logic [3:0]  settle_cnt;

    logic        vc_rise;
    logic        vc_fall;
    logic        step_chg;
    logic        in_sweep;
    logic        phase_edge;
    logic        accept;
    logic        take;
    logic [9:0]  step_sat;

    assign vc_rise  = V_C & ~vc_q;
    assign vc_fall  = ~V_C & vc_q;
    assign step_chg = (STEP != step_q);
    assign in_sweep = (state == S_COARSE) || (state == S_FINE);

    // A phase change (coarse->fine, or restart back to coarse) takes priority
    // over any sample arriving in the same cycle.
    assign phase_edge = ((state == S_COARSE) && vc_rise) ||
                        (((state == S_FINE) || (state == S_DONE)) && vc_fall);

    // A sample is only trusted once the lens has settled on an unchanged step.
    assign accept = in_sweep && SHARP_VALID && !phase_edge && !step_chg &&
                    (settle_cnt == 4'd0);

    // Strictly greater: ties keep the first-seen step.
    assign take = accept && (SHARP > PEAK_VAL);

    assign step_sat = STEP[10] ? 10'h3FF : STEP[9:0];

    // State register
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = V_C ? S_FINE : S_COARSE;
            S_COARSE: if (vc_rise) state_nxt = S_FINE;
            S_FINE: begin
                if (vc_fall) begin
                    state_nxt = S_COARSE;
                end else if (VCM_END) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   if (vc_fall) state_nxt = S_COARSE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        BUSY = 1'b0;
        DONE = 1'b0;
        case (state)
            S_COARSE: BUSY = 1'b1;
            S_FINE:   BUSY = 1'b1;
            S_DONE:   DONE = 1'b1;
            default:  ;
        endcase
    end

    // Input history used for edge and step-change detection
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            step_q <= 11'd0;
            vc_q   <= 1'b0;
        end else begin
            step_q <= STEP;
            vc_q   <= V_C;
        end
    end

    // Settle counter: reload on any lens move or phase change, otherwise
    // consume one frame per strobe while sweeping, stopping at zero.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            settle_cnt <= SETTLE_LD;
        end else if (step_chg || phase_edge) begin
            settle_cnt <= SETTLE_LD;
        end else if (in_sweep && SHARP_VALID && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Peak value and best-step capture
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            PEAK_VAL  <= '0;
            STEP_UP   <= 10'd0;
            BEST_STEP <= 10'd0;
        end else if (phase_edge) begin
            PEAK_VAL <= '0;
        end else if (take) begin
            PEAK_VAL <= SHARP;
            if (state == S_COARSE) begin
                STEP_UP <= step_sat;
            end else begin
                BEST_STEP <= step_sat;
            end
        end
    end

endmodule

// File: tb/tb_vcm_peak_track.sv
// tb/tb_vcm_peak_track.sv - scoreboard bench for vcm_peak_track

module tb_vcm_peak_track;

    logic        CLK;
    logic        RESET_n;
    logic [10:0] STEP;
    logic        V_C;
    logic        VCM_END;
    logic        SHARP_VALID;
    logic [23:0] SHARP;
    logic [9:0]  STEP_UP;
    logic [9:0]  BEST_STEP;
    logic [23:0] PEAK_VAL;
    logic        BUSY;
    logic        DONE;

    vcm_peak_track #(.SETTLE(2), .SW(24)) dut (
        .CLK         (CLK),
        .RESET_n     (RESET_n),
        .STEP        (STEP),
        .V_C         (V_C),
        .VCM_END     (VCM_END),
        .SHARP_VALID (SHARP_VALID),
        .SHARP       (SHARP),
        .STEP_UP     (STEP_UP),
        .BEST_STEP   (BEST_STEP),
        .PEAK_VAL    (PEAK_VAL),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          target;
        string       name;
        logic [9:0]  su;
        logic [9:0]  bs;
        logic [23:0] pk;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Monitor: compares every expectation whose cycle has come, on the falling edge
    always @(negedge CLK) begin
        exp_t e;
        while (q.size() > 0 && q[0].target <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (STEP_UP !== e.su || BEST_STEP !== e.bs || PEAK_VAL !== e.pk ||
                BUSY !== e.busy || DONE !== e.done) begin
                n_bad++;
                $display("FAIL %s: got step_up=%0d best=%0d peak=%0d busy=%0b done=%0b, want step_up=%0d best=%0d peak=%0d busy=%0b done=%0b",
                         e.name, STEP_UP, BEST_STEP, PEAK_VAL, BUSY, DONE,
                         e.su, e.bs, e.pk, e.busy, e.done);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_now(input string nm, input logic [9:0] su, input logic [9:0] bs,
                              input logic [23:0] pk, input logic b, input logic d);
        exp_t e;
        e.target = cyc;
        e.name   = nm;
        e.su     = su;
        e.bs     = bs;
        e.pk     = pk;
        e.busy   = b;
        e.done   = d;
        q.push_back(e);
    endtask

    task automatic frame(input logic [23:0] s);
        SHARP       = s;
        SHARP_VALID = 1'b1;
        tick();
        SHARP_VALID = 1'b0;
        tick();
    endtask

    // Move the lens, then three frames: two settle discards (high decoys) and one real
    task automatic sweep_step(input logic [10:0] st, input logic [23:0] val);
        STEP = st;
        tick();
        frame(24'd999);
        frame(24'd999);
        frame(val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int d;
        RESET_n     = 1'b0;
        STEP        = 11'd0;
        V_C         = 1'b0;
        VCM_END     = 1'b0;
        SHARP_VALID = 1'b0;
        SHARP       = 24'd0;
        tick();
        tick();
        expect_now("reset_state", 10'd0, 10'd0, 24'd0, 1'b0, 1'b0);
        tick();
        RESET_n = 1'b1;
        tick();

        // Coarse sweep
        sweep_step(11'd0, 24'd100);
        expect_now("coarse_0", 10'd0, 10'd0, 24'd100, 1'b1, 1'b0);
        sweep_step(11'd16, 24'd300);
        expect_now("coarse_16", 10'd16, 10'd0, 24'd300, 1'b1, 1'b0);
        sweep_step(11'd32, 24'd300);
        expect_now("coarse_tie_32", 10'd16, 10'd0, 24'd300, 1'b1, 1'b0);
        sweep_step(11'd48, 24'd500);
        expect_now("coarse_48", 10'd48, 10'd0, 24'd500, 1'b1, 1'b0);
        sweep_step(11'd64, 24'd200);
        sweep_step(11'd80, 24'd50);
        expect_now("coarse_end", 10'd48, 10'd0, 24'd500, 1'b1, 1'b0);

        // V_C rise together with a sample: phase change wins
        V_C         = 1'b1;
        SHARP       = 24'd999;
        SHARP_VALID = 1'b1;
        tick();
        SHARP_VALID = 1'b0;
        expect_now("to_fine", 10'd48, 10'd0, 24'd0, 1'b1, 1'b0);

        // Fine sweep 40..56, peak 700 at 51
        for (int s = 40; s <= 56; s++) begin
            d = (s > 51) ? (s - 51) : (51 - s);
            sweep_step(11'(s), 24'(700 - 20 * d));
            if (s == 51) expect_now("fine_51", 10'd48, 10'd51, 24'd700, 1'b1, 1'b0);
        end
        expect_now("fine_end", 10'd48, 10'd51, 24'd700, 1'b1, 1'b0);

        VCM_END = 1'b1;
        tick();
        expect_now("done", 10'd48, 10'd51, 24'd700, 1'b0, 1'b1);
        frame(24'd999);
        expect_now("done_ignore", 10'd48, 10'd51, 24'd700, 1'b0, 1'b1);

        // Restart: falling V_C from DONE
        V_C     = 1'b0;
        VCM_END = 1'b0;
        tick();
        expect_now("restart", 10'd48, 10'd51, 24'd0, 1'b1, 1'b0);

        sweep_step(11'd1000, 24'd100);
        expect_now("coarse_1000", 10'd1000, 10'd51, 24'd100, 1'b1, 1'b0);
        sweep_step(11'd1040, 24'd800);
        expect_now("saturate", 10'd1023, 10'd51, 24'd800, 1'b1, 1'b0);

        // Step change and sample in the same cycle: discarded, counter reloaded
        STEP        = 11'd1050;
        SHARP       = 24'hFFFFFF;
        SHARP_VALID = 1'b1;
        tick();
        SHARP_VALID = 1'b0;
        tick();
        expect_now("chg_same_cycle", 10'd1023, 10'd51, 24'd800, 1'b1, 1'b0);
        frame(24'd900);
        expect_now("reload_discard", 10'd1023, 10'd51, 24'd800, 1'b1, 1'b0);
        frame(24'd900);
        frame(24'd900);
        expect_now("reload_accept", 10'd1023, 10'd51, 24'd900, 1'b1, 1'b0);

        // Second fine sweep, STEP_UP must hold
        V_C = 1'b1;
        tick();
        expect_now("to_fine2", 10'd1023, 10'd51, 24'd0, 1'b1, 1'b0);
        sweep_step(11'd45, 24'd650);
        expect_now("fine2_45", 10'd1023, 10'd45, 24'd650, 1'b1, 1'b0);
        sweep_step(11'd51, 24'd700);
        expect_now("fine2_51", 10'd1023, 10'd51, 24'd700, 1'b1, 1'b0);

        // Asynchronous reset mid-fine: clears before the next rising edge
        tick();
        #1;
        RESET_n = 1'b0;
        V_C     = 1'b0;
        STEP    = 11'd0;
        expect_now("async_reset", 10'd0, 10'd0, 24'd0, 1'b0, 1'b0);
        tick();
        RESET_n = 1'b1;
        expect_now("release_idle", 10'd0, 10'd0, 24'd0, 1'b0, 1'b0);
        tick();
        expect_now("release_coarse", 10'd0, 10'd0, 24'd0, 1'b1, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
